// File: rtl/direction_judge.sv
// Trial sequencer for the direction-acuity test: requests a direction, latches it,
// waits for one arrow key (or timeout), scores it, and advances or ends the level.
module direction_judge #(
  parameter int TIMEOUT_CYC = 50000000,
  parameter int SETTLE      = 2,
  parameter int TRIALS      = 3,
  parameter int PASS_NEED   = 2,
  parameter int MAX_LEVEL   = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] ran_num,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic       new_req,
  output logic [2:0] target,
  output logic [3:0] level,
  output logic [1:0] trial_idx,
  output logic       hit,
  output logic       miss,
  output logic       busy,
  output logic       done,
  output logic [3:0] final_level
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_WAIT, S_JUDGE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            new_req_q, new_req_d;
  logic [2:0]      target_q, target_d;
  logic [3:0]      level_q, level_d;
  logic [1:0]      trial_q, trial_d;
  logic            hit_q, hit_d;
  logic            miss_q, miss_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [3:0]      final_q, final_d;
  logic [1:0]      hit_cnt_q, hit_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [SW-1:0]   settle_q, settle_d;

  logic [2:0] n_keys;
  logic [2:0] key_code;

  assign n_keys = 3'(key_up) + 3'(key_down) + 3'(key_left) + 3'(key_right);

  always_comb begin
    key_code = 3'd0;
    if (key_up)         key_code = 3'd1;
    else if (key_down)  key_code = 3'd2;
    else if (key_left)  key_code = 3'd3;
    else if (key_right) key_code = 3'd4;
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    level_d   = level_q;
    trial_d   = trial_q;
    final_d   = final_q;
    hit_cnt_d = hit_cnt_q;
    timer_d   = timer_q;
    settle_d  = settle_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          level_d   = 4'd1;
          trial_d   = 2'd0;
          hit_cnt_d = 2'd0;
          final_d   = 4'd0;
        end
      end
      S_LOAD: begin
        state_d  = S_SETTLE;
        settle_d = '0;
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE - 1)) begin
          target_d = (ran_num >= 3'd1 && ran_num <= 3'd4) ? ran_num : 3'd1;
          state_d  = S_WAIT;
          timer_d  = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_WAIT: begin
        // a key arriving on the expiry cycle is scored as that key
        if (n_keys == 3'd1) begin
          state_d = S_JUDGE;
          if (key_code == target_q) begin
            hit_d     = 1'b1;
            hit_cnt_d = hit_cnt_q + 1'b1;
          end else begin
            miss_d = 1'b1;
          end
        end else if (n_keys != 3'd0) begin
          state_d = S_JUDGE;
          miss_d  = 1'b1;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d = S_JUDGE;
          miss_d  = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_JUDGE: begin
        // hit_cnt already includes this trial's hit
        if (trial_q < 2'(TRIALS - 1)) begin
          trial_d = trial_q + 1'b1;
          state_d = S_LOAD;
        end else if (hit_cnt_q >= 2'(PASS_NEED)) begin
          final_d = level_q;
          if (level_q == 4'(MAX_LEVEL)) begin
            state_d = S_DONE;
          end else begin
            level_d   = level_q + 1'b1;
            trial_d   = 2'd0;
            hit_cnt_d = 2'd0;
            state_d   = S_LOAD;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    new_req_d = (state_d == S_LOAD);
    busy_d    = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
                (state_d == S_WAIT) || (state_d == S_JUDGE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      new_req_q <= 1'b0;
      target_q  <= 3'd0;
      level_q   <= 4'd0;
      trial_q   <= 2'd0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      final_q   <= 4'd0;
      hit_cnt_q <= 2'd0;
      timer_q   <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      new_req_q <= new_req_d;
      target_q  <= target_d;
      level_q   <= level_d;
      trial_q   <= trial_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      final_q   <= final_d;
      hit_cnt_q <= hit_cnt_d;
      timer_q   <= timer_d;
      settle_q  <= settle_d;
    end
  end

  assign new_req     = new_req_q;
  assign target      = target_q;
  assign level       = level_q;
  assign trial_idx   = trial_q;
  assign hit         = hit_q;
  assign miss        = miss_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign final_level = final_q;

endmodule
